// File: rtl/immu_mr_ctrl.sv
// immu_mr_ctrl: controller for the IMMU ITLB match-register array held in a
// 64x14 single-port SRAM (word = {VPN[12:0], V}).
// Serves fetch lookups (one per cycle sustained), SPR read/write of single
// entries, and an invalidation sweep of all 64 entries.
// Optional feature macro: IMMU_MR_INIT_EN enables the post-reset / inv_all
// sweep. Without it, reset goes straight to IDLE and inv_all is ignored.
// The address split requires VA_WIDTH - PAGE_BITS - 6 == 13.
module immu_mr_ctrl #(
    parameter int VA_WIDTH  = 32,
    parameter int PAGE_BITS = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [VA_WIDTH-1:0] req_vaddr,
    output logic                req_ready,
    output logic                resp_valid,
    output logic                resp_hit,
    input  logic                spr_cs,
    input  logic                spr_write,
    input  logic [5:0]          spr_addr,
    input  logic [31:0]         spr_dat_i,
    output logic [31:0]         spr_dat_o,
    output logic                spr_ack,
    input  logic                inv_all,
    output logic                init_busy,
    output logic [5:0]          sram_a,
    output logic                sram_csb,
    output logic                sram_web,
    output logic                sram_oeb,
    output logic [13:0]         sram_i,
    input  logic [13:0]         sram_o
);

    localparam int IDX_W = 6;
    localparam int TAG_W = VA_WIDTH - PAGE_BITS - IDX_W;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_CMP  = 2'd2,
        S_SACK = 2'd3
    } state_t;

`ifdef IMMU_MR_INIT_EN
    localparam state_t RST_STATE = S_INIT;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    state_t             r_state;
    state_t             w_next;
    logic [TAG_W-1:0]   r_tag_q;
    logic               r_spr_rd;
    logic               w_spr_go;
    logic               w_req_go;
    logic               w_inv;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_unused_bits;

    assign w_idx = req_vaddr[PAGE_BITS +: IDX_W];
    assign w_tag = req_vaddr[PAGE_BITS + IDX_W +: TAG_W];

    // Page offset and the SPR data bits between VPN and V carry no state.
    assign w_unused_bits = ^{req_vaddr[PAGE_BITS-1:0], spr_dat_i[18:1]};

`ifdef IMMU_MR_INIT_EN
    logic [IDX_W-1:0] r_cnt;

    assign w_inv = inv_all;

    // Sweep counter: advances only while sweeping, inv_all restarts it at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_INIT && !inv_all) begin
            r_cnt <= r_cnt + 6'd1;
        end else begin
            r_cnt <= '0;
        end
    end
`else
    logic w_unused_inv;

    // Without the sweep there is nothing for inv_all to request.
    assign w_inv        = 1'b0;
    assign w_unused_inv = inv_all;
`endif

    // State register; reset aborts any sweep, lookup or SPR access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    // Lookup tag and SPR direction are captured when the access is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_q  <= '0;
            r_spr_rd <= 1'b0;
        end else begin
            if (w_req_go) begin
                r_tag_q <= w_tag;
            end
            if (w_spr_go) begin
                r_spr_rd <= !spr_write;
            end
        end
    end

    // Next state, arbitration and combinational SRAM controls.
    always_comb begin
        w_next     = r_state;
        w_spr_go   = 1'b0;
        w_req_go   = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        spr_ack    = 1'b0;
        spr_dat_o  = '0;
        init_busy  = 1'b0;
        sram_a     = '0;
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_oeb   = 1'b1;
        sram_i     = '0;
        case (r_state)
`ifdef IMMU_MR_INIT_EN
            S_INIT: begin
                init_busy = 1'b1;
                sram_csb  = 1'b0;
                sram_web  = 1'b0;
                sram_a    = r_cnt;
                if (!inv_all && r_cnt == 6'd63) begin
                    w_next = S_IDLE;
                end
            end
`endif
            S_IDLE, S_CMP: begin
                // sram_o holds the word read at the accepting edge; a new
                // read issued now only lands after the coming edge.
                if (r_state == S_CMP) begin
                    resp_valid = 1'b1;
                    resp_hit   = sram_o[0] && (sram_o[13:1] == r_tag_q);
                    sram_oeb   = 1'b0;
                end
                req_ready = !w_inv && !spr_cs;
                if (w_inv) begin
                    w_next = S_INIT;
                end else if (spr_cs) begin
                    w_spr_go = 1'b1;
                    sram_csb = 1'b0;
                    sram_web = !spr_write;
                    sram_a   = spr_addr;
                    sram_i   = {spr_dat_i[31:19], spr_dat_i[0]};
                    w_next   = S_SACK;
                end else if (req_valid) begin
                    w_req_go = 1'b1;
                    sram_csb = 1'b0;
                    sram_a   = w_idx;
                    w_next   = S_CMP;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_SACK: begin
                spr_ack  = 1'b1;
                sram_oeb = 1'b0;
                if (r_spr_rd) begin
                    spr_dat_o = {sram_o[13:1], 18'b0, sram_o[0]};
                end
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_immu_mr_ctrl.sv
// tb_immu_mr_ctrl: bench for immu_mr_ctrl with a behavioural 64x14 SRAM.
// Expectations follow IMMU_MR_INIT_EN when it is defined for the build.
module tb_immu_mr_ctrl;

`ifdef IMMU_MR_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif
    localparam int SWEEP_N = INIT_EN ? 64 : 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_vaddr;
    logic        req_ready, resp_valid, resp_hit;
    logic        spr_cs, spr_write;
    logic [5:0]  spr_addr;
    logic [31:0] spr_dat_i, spr_dat_o;
    logic        spr_ack;
    logic        inv_all, init_busy;
    logic [5:0]  sram_a;
    logic        sram_csb, sram_web, sram_oeb;
    logic [13:0] sram_i;
    logic [13:0] sram_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct { logic [31:0] va; logic hit; } lk_t;
    typedef struct { logic hit; int cyc; } sb_t;
    lk_t tbl[8];
    sb_t sb[$];

    logic [13:0] mem [64];

    immu_mr_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_vaddr(req_vaddr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_hit(resp_hit),
        .spr_cs(spr_cs), .spr_write(spr_write), .spr_addr(spr_addr),
        .spr_dat_i(spr_dat_i), .spr_dat_o(spr_dat_o), .spr_ack(spr_ack),
        .inv_all(inv_all), .init_busy(init_busy),
        .sram_a(sram_a), .sram_csb(sram_csb), .sram_web(sram_web),
        .sram_oeb(sram_oeb), .sram_i(sram_i), .sram_o(sram_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port SRAM: registered read, write on csb=0 & web=0.
    initial begin
        sram_o = '0;
        for (int i = 0; i < 64; i++) mem[i] = {13'h1ABC ^ 13'(i), 1'b1};
    end
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) mem[sram_a] <= sram_i;
            else           sram_o <= mem[sram_a];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response monitor: every resp_valid must match the oldest accepted lookup.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_unexpected: got resp_valid=1 expected none");
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("resp_hit", {31'd0, resp_hit}, {31'd0, e.hit});
                check("resp_cycle", cyc, e.cyc);
                check("resp_oeb", {31'd0, sram_oeb}, 32'd0);
            end
        end
    end

    task automatic sweep_check(input string nm, input int exp_n);
        int n = 0;
        forever begin
            @(negedge clk);
            if (!init_busy) break;
            check({nm, "_wr"}, {sram_csb, sram_web, sram_a, sram_i, req_ready},
                  {1'b0, 1'b0, 6'(n), 14'd0, 1'b0});
            @(posedge clk);
            n++;
            if (n > 100) break;
        end
        check({nm, "_len"}, n, exp_n);
        check({nm, "_rdy"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    // Wait for req_ready (bounded), log the expectation, then let the edge accept it.
    task automatic accept_lookup(input logic [31:0] va, input logic hit);
        int n = 0;
        req_valid = 1'b1;
        req_vaddr = va;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 50) break;
            @(posedge clk);
        end
        check("lk_ready", {31'd0, req_ready}, 32'd1);
        check("lk_issue", {sram_csb, sram_web, sram_a}, {1'b0, 1'b1, va[18:13]});
        sb.push_back('{hit: hit, cyc: cyc + 1});
        @(posedge clk); #1;
    endtask

    task automatic spr_access(input logic wr, input logic [5:0] addr,
                              input logic [31:0] dat, output logic [31:0] rdata);
        int n = 0;
        spr_cs    = 1'b1;
        spr_write = wr;
        spr_addr  = addr;
        spr_dat_i = dat;
        forever begin
            @(negedge clk);
            if (spr_ack) break;
            if (n == 0)
                check("spr_issue", {sram_csb, sram_web, sram_a, sram_i},
                      {1'b0, !wr, addr, dat[31:19], dat[0]});
            n++;
            if (n > 50) break;
            @(posedge clk);
        end
        check("spr_ack_lat", n, 1);
        check("spr_sack_oeb", {sram_oeb, req_ready}, {1'b0, 1'b0});
        rdata = spr_dat_o;
        @(posedge clk); #1;
        spr_cs = 1'b0;
        @(negedge clk);
        check("spr_ack_pulse", {spr_ack, spr_dat_o}, 33'd0);
        check("idle_sram", {sram_csb, sram_web, sram_oeb, sram_a, sram_i},
              {1'b1, 1'b1, 1'b1, 6'd0, 14'd0});
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        int n;

        tbl[0] = '{va: 32'h0008_A000, hit: 1'b1};
        tbl[1] = '{va: 32'h0000_0000, hit: 1'b0};
        tbl[2] = '{va: 32'h0010_A000, hit: 1'b0};
        tbl[3] = '{va: 32'h0008_BFFF, hit: 1'b1};
        tbl[4] = '{va: 32'hFFFF_E000, hit: 1'b1};
        tbl[5] = '{va: 32'h0551_4000, hit: 1'b0};
        tbl[6] = '{va: 32'hFFFF_C000, hit: 1'b0};
        tbl[7] = '{va: 32'h0008_A000, hit: 1'b1};

        rst_n = 1'b0; req_valid = 1'b0; req_vaddr = '0;
        spr_cs = 1'b0; spr_write = 1'b0; spr_addr = '0; spr_dat_i = '0;
        inv_all = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp", {resp_valid, resp_hit, spr_ack}, 3'b000);
        check("rst_dat", spr_dat_o, 32'd0);
        check("rst_busy", {31'd0, init_busy}, {31'd0, INIT_EN});
        check("rst_ready", {31'd0, req_ready}, {31'd0, !INIT_EN});
        check("rst_sram", {sram_oeb, sram_csb}, {1'b1, !INIT_EN});
        @(posedge clk); #1;
        rst_n = 1'b1;
        sweep_check("sweep", SWEEP_N);

        // SPR writes and read-backs.
        spr_access(1'b1, 6'd5, 32'h0008_0001, rd);
        spr_access(1'b1, 6'd10, 32'h0550_0000, rd);
        spr_access(1'b1, 6'd63, 32'hFFFF_FFFF, rd);
        spr_access(1'b0, 6'd5, 32'h0, rd);
        check("spr_rd5", rd, 32'h0008_0001);
        spr_access(1'b0, 6'd10, 32'h0, rd);
        check("spr_rd10", rd, 32'h0550_0000);
        spr_access(1'b0, 6'd63, 32'h0, rd);
        check("spr_rd63", rd, 32'hFFF8_0001);

        // Back-to-back lookups from the table.
        for (int i = 0; i < 8; i++) accept_lookup(tbl[i].va, tbl[i].hit);
        req_valid = 1'b0;
        repeat (2) @(posedge clk); #1;

        // SPR and lookup together: SPR wins, lookup taken right after SACK.
        spr_cs = 1'b1; spr_write = 1'b0; spr_addr = 6'd5;
        req_valid = 1'b1; req_vaddr = 32'h0008_A000;
        n = 0;
        forever begin
            @(negedge clk);
            if (spr_ack) break;
            check("arb_ready", {31'd0, req_ready}, 32'd0);
            n++;
            if (n > 50) break;
            @(posedge clk);
        end
        check("arb_ack_lat", n, 1);
        check("arb_rd", spr_dat_o, 32'h0008_0001);
        @(posedge clk); #1;
        spr_cs = 1'b0;
        @(negedge clk);
        check("arb_ready_after", {spr_ack, req_ready}, {1'b0, 1'b1});
        sb.push_back('{hit: 1'b1, cyc: cyc + 1});
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk); #1;

        // inv_all, then a second inv_all mid-sweep restarting it.
        inv_all = 1'b1;
        @(negedge clk);
        check("inv_ready", {31'd0, req_ready}, {31'd0, !INIT_EN});
        @(posedge clk); #1;
        inv_all = 1'b0;
        repeat (10) @(posedge clk);
        #1 inv_all = 1'b1;
        @(posedge clk); #1;
        inv_all = 1'b0;
        sweep_check("resweep", SWEEP_N);
        accept_lookup(32'h0008_A000, !INIT_EN);
        req_valid = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset during a lookup: no response, sweep restarts at 0.
        accept_lookup(32'h0008_A000, !INIT_EN);
        rst_n = 1'b0;
        req_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_lk_resp", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sweep_check("sweep_lk", SWEEP_N);

        // Reset during an SPR access: no acknowledge.
        spr_cs = 1'b1; spr_write = 1'b1; spr_addr = 6'd7; spr_dat_i = 32'h1234_5679;
        @(posedge clk); #1;
        rst_n = 1'b0;
        spr_cs = 1'b0;
        @(negedge clk);
        check("rst_spr_ack", {spr_ack, spr_dat_o}, 33'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sweep_check("sweep_spr", SWEEP_N);

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
